// File: rtl/cpu4_pkg.sv
// Shared opcode map and sequencer state type for the 4-bit CPU.
// Instruction word: opcode in [7:4], immediate operand in [3:0].
package cpu4_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_SWP = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JOV = 4'b1010;
    localparam logic [3:0] OP_CLO = 4'b1011;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } seq_state_t;

    // Opcodes that are forwarded to the external ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-ROM and ALU bus between the sequencer (master) and the datapath
// blocks it drives (slave side: ROM and external ALU).
interface alu_sequencer_if #(
    parameter int unsigned PC_W = 4
);
    logic [PC_W-1:0] rom_addr;
    logic            rom_en;
    logic [7:0]      rom_data;
    logic [3:0]      alu_op;
    logic [3:0]      alu_a;
    logic [3:0]      alu_b;
    logic [3:0]      alu_result;
    logic            alu_ovf;

    modport master (
        output rom_addr, rom_en, alu_op, alu_a, alu_b,
        input  rom_data, alu_result, alu_ovf
    );

    modport slave (
        input  rom_addr, rom_en, alu_op, alu_a, alu_b,
        output rom_data, alu_result, alu_ovf
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 4-bit CPU: fetches from a synchronous ROM,
// owns A/B/PC, drives the external ALU and writes results back (4 cycles/instr).
module alu_sequencer
    import cpu4_pkg::*;
#(
    parameter int unsigned    PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    alu_sequencer_if.master     bus,
    output logic [3:0]          acc_out,
    output logic                ovf_flag,
    output logic                busy,
    output logic                halted
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [7:0]      ir_q, ir_d;
    logic            ovf_q, ovf_d;
    logic            rom_en_q, rom_en_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        a_d       = a_q;
        b_d       = b_q;
        ir_d      = ir_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    ovf_d   = 1'b0;
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                ir_d    = bus.rom_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d   = WB;
                next_pc_d = pc_q + PC_W'(1);
                case (ir_q[7:4])
                    OP_LDA: a_d = ir_q[3:0];
                    OP_LDB: b_d = ir_q[3:0];
                    OP_SWP: begin
                        a_d = b_q;
                        b_d = a_q;
                    end
                    OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT: begin
                        // On overflow the ALU result is discarded; A keeps its value.
                        if (bus.alu_ovf) ovf_d = 1'b1;
                        else             a_d   = bus.alu_result;
                    end
                    OP_JMP: next_pc_d = PC_W'(ir_q[3:0]);
                    OP_JOV: begin
                        if (ovf_q) next_pc_d = PC_W'(ir_q[3:0]);
                        ovf_d = 1'b0;
                    end
                    OP_CLO: ovf_d = 1'b0;
                    default: ;
                endcase
            end
            WB: begin
                pc_d    = next_pc_q;
                state_d = (ir_q[7:4] == OP_HLT) ? HALT : FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        rom_en_d = (state_d == FETCH);
        busy_d   = (state_d inside {FETCH, DECODE, EXEC, WB});
        halted_d = (state_d == HALT);
        alu_op_d = ((state_d == EXEC) && is_alu_op(ir_d[7:4])) ? ir_d[7:4] : OP_NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            a_q       <= '0;
            b_q       <= '0;
            ir_q      <= '0;
            ovf_q     <= 1'b0;
            rom_en_q  <= 1'b0;
            alu_op_q  <= OP_NOP;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ir_q      <= ir_d;
            ovf_q     <= ovf_d;
            rom_en_q  <= rom_en_d;
            alu_op_q  <= alu_op_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.rom_addr = pc_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign acc_out      = a_q;
    assign ovf_flag     = ovf_q;
    assign busy         = busy_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table of whole programs plus
// hand-written sequences for JOV looping, PC wrap, restart and async reset.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] acc_out;
    logic       ovf_flag;
    logic       busy;
    logic       halted;

    alu_sequencer_if #(.PC_W(4)) bus ();

    alu_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .acc_out  (acc_out),
        .ovf_flag (ovf_flag),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    // Reference ALU: combinational, holds its outputs on unmatched opcodes.
    logic [4:0] sum5;
    always @(bus.alu_op or bus.alu_a or bus.alu_b) begin
        case (bus.alu_op)
            4'h4: begin
                sum5 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result = sum5[3:0];
                bus.alu_ovf    = sum5[4];
            end
            4'h5: begin
                bus.alu_result = bus.alu_a - bus.alu_b;
                bus.alu_ovf    = (bus.alu_a < bus.alu_b);
            end
            4'h6: begin bus.alu_result = bus.alu_a | bus.alu_b; bus.alu_ovf = 1'b0; end
            4'h7: begin bus.alu_result = bus.alu_a & bus.alu_b; bus.alu_ovf = 1'b0; end
            4'h8: begin bus.alu_result = ~bus.alu_a;            bus.alu_ovf = 1'b0; end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Program byte 0 sits in prog[63:56]; unused slots are filled with HLT.
    task automatic load_rom(input logic [63:0] prog);
        for (int k = 0; k < 16; k++)
            rom[k] = (k < 8) ? prog[63-8*k -: 8] : 8'hF0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] prog;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        ovf;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int cyc;

        vecs[0]  = '{"add",        64'h19_25_40_F0_F0_F0_F0_F0, 4'd14, 4'd5,  1'b0, 16};
        vecs[1]  = '{"add_ovf",    64'h1C_27_40_F0_F0_F0_F0_F0, 4'd12, 4'd7,  1'b1, 16};
        vecs[2]  = '{"sub_borrow", 64'h13_25_50_F0_F0_F0_F0_F0, 4'd3,  4'd5,  1'b1, 16};
        vecs[3]  = '{"sub",        64'h15_23_50_F0_F0_F0_F0_F0, 4'd2,  4'd3,  1'b0, 16};
        vecs[4]  = '{"or",         64'h1A_26_60_F0_F0_F0_F0_F0, 4'd14, 4'd6,  1'b0, 16};
        vecs[5]  = '{"and",        64'h1A_26_70_F0_F0_F0_F0_F0, 4'd2,  4'd6,  1'b0, 16};
        vecs[6]  = '{"logic_swp",  64'h1A_26_60_70_80_30_F0_F0, 4'd6,  4'd9,  1'b0, 28};
        vecs[7]  = '{"jov_taken",  64'h1C_27_40_A6_11_12_F0_F0, 4'd12, 4'd7,  1'b0, 20};
        vecs[8]  = '{"jov_not",    64'h11_A4_17_F0_F0_F0_F0_F0, 4'd7,  4'd0,  1'b0, 16};
        vecs[9]  = '{"jmp",        64'h93_11_12_14_F0_F0_F0_F0, 4'd4,  4'd0,  1'b0, 12};
        vecs[10] = '{"clo",        64'h1C_27_40_B0_F0_F0_F0_F0, 4'd12, 4'd7,  1'b0, 20};
        vecs[11] = '{"nop_undef",  64'h15_C3_D0_E7_00_F0_F0_F0, 4'd5,  4'd0,  1'b0, 24};
        vecs[12] = '{"ovf_swp",    64'h1C_27_40_30_F0_F0_F0_F0, 4'd7,  4'd12, 1'b1, 20};
        vecs[13] = '{"swp_zero",   64'h13_30_F0_F0_F0_F0_F0_F0, 4'd0,  4'd3,  1'b0, 12};

        // Reset state
        do_reset();
        check("rst_acc",    acc_out,      0);
        check("rst_ovf",    ovf_flag,     0);
        check("rst_busy",   busy,         0);
        check("rst_halted", halted,       0);
        check("rst_rom_en", bus.rom_en,   0);
        check("rst_alu_op", bus.alu_op,   0);
        check("rst_pc",     bus.rom_addr, 0);

        // Table of complete programs
        foreach (vecs[i]) begin
            do_reset();
            load_rom(vecs[i].prog);
            pulse_start();
            run_to_halt(cyc);
            check({vecs[i].name, "_cycles"}, cyc,       vecs[i].cyc);
            check({vecs[i].name, "_acc"},    acc_out,   vecs[i].a);
            check({vecs[i].name, "_b"},      bus.alu_b, vecs[i].b);
            check({vecs[i].name, "_ovf"},    ovf_flag,  vecs[i].ovf);
            check({vecs[i].name, "_busy"},   busy,      0);
            check({vecs[i].name, "_rom_en"}, bus.rom_en, 0);
        end

        // Restart from HALT clears the overflow flag and the PC
        do_reset();
        load_rom(64'h1C_27_40_F0_F0_F0_F0_F0);
        pulse_start();
        run_to_halt(cyc);
        check("restart_pre_ovf", ovf_flag, 1);
        pulse_start();
        check("restart_ovf",    ovf_flag,     0);
        check("restart_halted", halted,       0);
        check("restart_busy",   busy,         1);
        check("restart_pc",     bus.rom_addr, 0);
        check("restart_rom_en", bus.rom_en,   1);

        // Overflowing ADD followed by JOV 0 loops back and clears the flag
        do_reset();
        load_rom(64'h1C_27_40_A0_F0_F0_F0_F0);
        pulse_start();
        repeat (12) @(negedge clk);
        check("jov0_acc",     acc_out,      12);
        check("jov0_ovf_set", ovf_flag,     1);
        check("jov0_pc3",     bus.rom_addr, 3);
        repeat (4) @(negedge clk);
        check("jov0_pc",      bus.rom_addr, 0);
        check("jov0_ovf_clr", ovf_flag,     0);
        check("jov0_rom_en",  bus.rom_en,   1);

        // All-NOP ROM: PC wraps 15 -> 0, busy stays high, mid-run start ignored
        do_reset();
        for (int k = 0; k < 16; k++) rom[k] = 8'h00;
        pulse_start();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            start = (k == 10 || k == 37 || k == 59);
            check("nop_busy", busy, 1);
            if (k % 4 == 0) check("nop_pc", bus.rom_addr, (k / 4) % 16);
        end
        start = 1'b0;

        // Async reset during EXEC of ADD
        do_reset();
        load_rom(64'h19_25_40_F0_F0_F0_F0_F0);
        pulse_start();
        repeat (9) @(negedge clk);
        check("decode_alu_op", bus.alu_op, 0);
        @(negedge clk);
        check("exec_alu_op", bus.alu_op, 4);
        check("exec_acc",    acc_out,    9);
        #2 rst = 1'b1;
        #1;
        check("midrst_acc",    acc_out,      0);
        check("midrst_b",      bus.alu_b,    0);
        check("midrst_alu_op", bus.alu_op,   0);
        check("midrst_busy",   busy,         0);
        check("midrst_rom_en", bus.rom_en,   0);
        check("midrst_pc",     bus.rom_addr, 0);
        check("midrst_ovf",    ovf_flag,     0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy",   busy,       0);
        check("idle_rom_en", bus.rom_en, 0);
        check("idle_halted", halted,     0);
        check("idle_acc",    acc_out,    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
